uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters, e.g. the DHT11 report formatter and the uart_rx echo/command responder.
- Each requester offers packets as valid/ready byte streams with a last flag.
- Grants are round-robin at packet granularity, so a packet is never interleaved with another.
- Sits between the requesters and uart_tx, and sequences uart_tx through its send-enable / busy handshake.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- STALL_MAX, 1000000, clk cycles a granted requester may leave req_valid low mid-packet before its grant is revoked (20 ms at 50 MHz).
- CNT_W, 16, width of the sent-byte counter.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the last byte of its packet
- req_ready  out  NUM_REQ  byte accepted; combinational
- tx_en  out  1  one-cycle send pulse to uart_tx
- tx_data  out  8  byte to uart_tx; held stable until tx_busy falls
- tx_busy  in  1  uart_tx busy; rises the cycle after tx_en, falls after the stop bit
- grant_valid  out  1  a requester currently owns the transmitter
- grant_id  out  2  index of the owning requester
- stall_err  out  1  one-cycle pulse when a grant is revoked by stall timeout
- bytes_sent  out  CNT_W  count of bytes handed to uart_tx; wraps

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE; tx_en=0, tx_data=0, grant_valid=0, grant_id=0, stall_err=0, bytes_sent=0.
  - last_grant=NUM_REQ-1, so requester 0 wins the first arbitration.
  - req_ready=0 for all requesters.
- Reset mid-operation: the FSM abandons the packet immediately. A byte already inside uart_tx still completes on the line, but the arbiter ignores tx_busy once back in IDLE.
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid is high, pick the first set index searching from last_grant+1 modulo NUM_REQ.
  - Register grant_id and set grant_valid=1. Go to SEND.
  - Arbitration is one cycle; the first byte is accepted in SEND the next cycle at earliest.
- SEND:
  - req_ready[grant_id] = req_valid[grant_id] & ~tx_busy. All other ready bits are 0.
  - On handshake: register tx_data from the granted requester's req_data, pulse tx_en=1 for the next cycle, latch last_r=req_last[grant_id], increment bytes_sent, clear the stall counter, go to WAIT_BUSY.
  - With no handshake, the stall counter increments. When it reaches STALL_MAX-1: pulse stall_err, set grant_valid=0, last_grant=grant_id, go to IDLE. A packet is therefore never truncated silently.
- WAIT_BUSY:
  - Wait for tx_busy=1, then go to WAIT_DONE.
  - If tx_busy is still 0 after 4 cycles, treat the byte as sent and go to WAIT_DONE. This guards against a lost pulse.
- WAIT_DONE:
  - Wait for tx_busy=0.
  - If last_r=1: grant_valid=0, last_grant=grant_id, go to IDLE.
  - If last_r=0: go to SEND, keeping the grant.
- Valid and last interaction:
  - req_valid deasserting without last keeps the grant until the stall timeout.
  - Requesters not granted see req_ready=0 and must hold req_valid and req_data.
- Simultaneous requests: round-robin. When two requesters both hold packets, grants alternate, independent of requester index.
- Back-to-back packets from one requester: the grant is released and that requester drops to lowest priority. It re-wins only if no other requester is valid.
- Throughput: one byte per uart_tx frame plus 3 clk cycles (handshake, tx_en, busy release).
- bytes_sent: wraps from 2^CNT_W-1 to 0 with no flag.
- Width rule: grant_id is fixed at 2 bits. Upper bits are 0 when NUM_REQ=2.

Decomposition:
- Shared package uart_pkg:
  - state enum arb_state_t {IDLE, SEND, WAIT_BUSY, WAIT_DONE}
  - localparam BUSY_WAIT_MAX=4
  - function rr_pick(valid, last), returning the next index
- Sub-module rr_arbiter: a purely combinational round-robin picker, parameterised by NUM_REQ, taking valid and last_grant and returning idx and any. It is the natural reuse point; the FSM stays in uart_tx_arbiter.

Test Plan:
- Single-requester packet:
  - Stimulus: requester 0 sends 0x54,0x3D,0x32 (last on 0x32); uart_tx model holds busy 20 cycles.
  - Response: tx_data sequence 54,3D,32; three tx_en pulses; grant_valid high throughout and low after the third busy falls; bytes_sent=3.
- Contention:
  - Stimulus: both requesters assert at reset release; req0 sends packet A1,A2, req1 sends B1.
  - Response: order A1,A2,B1; grant_id 0 then 1; no B byte between A1 and A2.
- Round-robin fairness:
  - Stimulus: both requesters continuously offer 1-byte packets (req0 0x11, req1 0x22) for 6 packets.
  - Response: tx_data alternates 11,22,11,22,11,22.
- Stall timeout:
  - Stimulus: STALL_MAX=50; req0 sends 0xAA without last, then drops valid; req1 is pending.
  - Response: stall_err pulses once 50 cycles after the handshake window opens; grant passes to req1; req1's byte follows.
- Lost busy:
  - Stimulus: uart_tx model never raises tx_busy.
  - Response: the FSM leaves WAIT_BUSY after 4 cycles; the next byte is accepted; no deadlock.
- Reset mid-packet:
  - Stimulus: assert rst in WAIT_DONE.
  - Response: the next cycle shows grant_valid=0, tx_en=0, bytes_sent=0, req_ready=0; after release, req0 is granted first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM states,
// the lost-busy guard length and the round-robin pick function.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    localparam int BUSY_WAIT_MAX = 4;
    localparam int MAX_REQ       = 4;

    // First set bit of valid searching upward from last+1, wrapping at n.
    function automatic logic [1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [1:0]         last,
        input int                 n
    );
        logic [1:0] pick;
        logic [1:0] cand;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand = 2'((int'(last) + k) % n);
            if (k <= n && !found && valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker; zero latency, no state.
// Callers hold valid until granted; last_grant sets the lowest priority.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [1:0]         last_grant,
    output logic [1:0]         idx,
    output logic               any
);

    logic [MAX_REQ-1:0] valid_pad;

    assign valid_pad = MAX_REQ'(valid);
    assign idx       = rr_pick(valid_pad, last_grant, NUM_REQ);
    assign any       = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin share of one uart_tx; 1-cycle arbitration, one byte per frame + 3 clk.
// req_ready is combinational and only ever high for the granted requester while tx_busy is low.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int STALL_MAX = 1000000,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_en,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 grant_valid,
    output logic [1:0]           grant_id,
    output logic                 stall_err,
    output logic [CNT_W-1:0]     bytes_sent
);

    localparam int                 STALL_W    = (STALL_MAX > 2) ? $clog2(STALL_MAX) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);
    localparam int                 BUSY_W     = $clog2(BUSY_WAIT_MAX);
    localparam logic [BUSY_W-1:0]  BUSY_LAST  = BUSY_W'(BUSY_WAIT_MAX - 1);
    localparam logic [1:0]         LAST_INIT  = 2'(NUM_REQ - 1);

    arb_state_t         state;
    arb_state_t         state_next;
    logic [1:0]         last_grant;
    logic               last_r;
    logic [STALL_W-1:0] stall_cnt;
    logic [BUSY_W-1:0]  busy_cnt;

    logic [1:0]         arb_idx;
    logic               arb_any;
    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic               handshake;
    logic               stall_hit;
    logic               release_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .valid      (req_valid),
        .last_grant (last_grant),
        .idx        (arb_idx),
        .any        (arb_any)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 2'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        handshake     = 1'b0;
        stall_hit     = 1'b0;
        release_grant = 1'b0;
        req_ready     = '0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (sel_valid && !tx_busy) begin
                    handshake  = 1'b1;
                    state_next = WAIT_BUSY;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_ready[i] = (grant_id == 2'(i));
                    end
                end else if (stall_cnt == STALL_LAST) begin
                    stall_hit     = 1'b1;
                    release_grant = 1'b1;
                    state_next    = IDLE;
                end
            end
            // A tx_en lost inside uart_tx would otherwise park us here forever.
            WAIT_BUSY: begin
                if (tx_busy || busy_cnt == BUSY_LAST) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_r) begin
                        release_grant = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        state_next = SEND;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_en       <= 1'b0;
            tx_data     <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            stall_err   <= 1'b0;
            bytes_sent  <= '0;
            last_grant  <= LAST_INIT;
            last_r      <= 1'b0;
            stall_cnt   <= '0;
            busy_cnt    <= '0;
        end else begin
            tx_en     <= handshake;
            stall_err <= stall_hit;
            if (state == IDLE && arb_any) begin
                grant_valid <= 1'b1;
                grant_id    <= arb_idx;
            end
            if (release_grant) begin
                grant_valid <= 1'b0;
                last_grant  <= grant_id;
            end
            if (handshake) begin
                tx_data    <= sel_data;
                last_r     <= sel_last;
                bytes_sent <= bytes_sent + CNT_W'(1);
            end
            if (state == SEND && !handshake && !stall_hit) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end else begin
                stall_cnt <= '0;
            end
            if (state == WAIT_BUSY && state_next == WAIT_BUSY) begin
                busy_cnt <= busy_cnt + BUSY_W'(1);
            end else begin
                busy_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a uart_tx busy model,
// and a packet-level round-robin reference model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NUM_REQ   = 2;
    localparam int STALL_MAX = 50;
    localparam int CNT_W     = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_en;
    logic [7:0]           tx_data;
    logic                 tx_busy = 1'b0;
    logic                 grant_valid;
    logic [1:0]           grant_id;
    logic                 stall_err;
    logic [CNT_W-1:0]     bytes_sent;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .STALL_MAX (STALL_MAX),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .stall_err   (stall_err),
        .bytes_sent  (bytes_sent)
    );

    // Per-requester byte streams, {last, data}; the driver pops on handshake.
    logic [8:0] q [NUM_REQ][$];
    logic [9:0] got_q[$];
    logic       got_gv[$];
    logic [9:0] exp_q[$];
    int         tx_en_cyc[$];
    int         busy_fall_q[$];
    int         exp_stalls;
    int         cyc = 0;
    int         stall_seen = 0;
    int         stall_seen_cyc = 0;
    int         gv_fall_cyc = 0;
    logic       gv_prev = 1'b0;
    int         busy_len = 20;
    bit         busy_lost = 1'b0;
    bit         hs [NUM_REQ];
    int         vectors = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Requester driver: present queue heads at negedge, note handshakes just after.
    initial begin
        for (int i = 0; i < NUM_REQ; i++) hs[i] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i] && q[i].size() > 0) void'(q[i].pop_front());
                if (q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_last[i]        = q[i][0][8];
                    req_data[8*i +: 8] = q[i][0][7:0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            #1;
            for (int i = 0; i < NUM_REQ; i++) hs[i] = req_valid[i] && req_ready[i] && !rst;
        end
    end

    // uart_tx model: busy rises the cycle after tx_en, holds busy_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_en === 1'b1 && !busy_lost) begin
                @(negedge clk);
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tx_busy = 1'b0;
                busy_fall_q.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            got_q.push_back({grant_id, tx_data});
            got_gv.push_back(grant_valid);
            tx_en_cyc.push_back(cyc);
        end
        if (stall_err === 1'b1) begin
            stall_seen++;
            stall_seen_cyc = cyc;
        end
        if (gv_prev === 1'b1 && grant_valid === 1'b0) gv_fall_cyc = cyc;
        gv_prev = grant_valid;
    end

    // Reference: whole packets granted round-robin among non-empty streams;
    // a stream that runs dry before its last byte costs one stall timeout.
    task automatic model_run();
        logic [8:0] mq [NUM_REQ][$];
        logic [8:0] b;
        int  last;
        int  idx;
        bit  found;
        bit  done_pkt;
        for (int i = 0; i < NUM_REQ; i++) mq[i] = q[i];
        exp_q.delete();
        exp_stalls = 0;
        last = NUM_REQ - 1;
        idx  = 0;
        while (1) begin
            found = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!found && mq[(last + k) % NUM_REQ].size() > 0) begin
                    found = 1'b1;
                    idx   = (last + k) % NUM_REQ;
                end
            end
            if (!found) break;
            done_pkt = 1'b0;
            while (!done_pkt) begin
                if (mq[idx].size() == 0) begin
                    exp_stalls++;
                    done_pkt = 1'b1;
                end else begin
                    b = mq[idx].pop_front();
                    exp_q.push_back({2'(idx), b[7:0]});
                    done_pkt = b[8];
                end
            end
            last = idx;
        end
    endtask

    function automatic bit q_empty();
        bit e = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) q[i].delete();
        repeat (2) @(negedge clk);
        got_q.delete();
        got_gv.delete();
        tx_en_cyc.delete();
        busy_fall_q.delete();
        stall_seen     = 0;
        stall_seen_cyc = 0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (n < budget && !(q_empty() && grant_valid === 1'b0 && tx_busy === 1'b0)) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_drain: still busy after %0d cycles (grant_valid=%b), required idle", name, n, grant_valid);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        q[0].push_back(9'h0AB);
        q[1].push_back(9'h1CD);
        repeat (3) @(negedge clk);
        vectors++; if (tx_en !== 1'b0)       begin errors++; $display("FAIL rst_tx_en: got %b want 0", tx_en); end
        vectors++; if (tx_data !== 8'h00)    begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        vectors++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rst_grant_valid: got %b want 0", grant_valid); end
        vectors++; if (grant_id !== 2'd0)    begin errors++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
        vectors++; if (stall_err !== 1'b0)   begin errors++; $display("FAIL rst_stall_err: got %b want 0", stall_err); end
        vectors++; if (bytes_sent !== '0)    begin errors++; $display("FAIL rst_bytes_sent: got %0d want 0", bytes_sent); end
        vectors++; if (req_ready !== '0)     begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    endtask

    task automatic test_single();
        apply_reset();
        busy_len = 20;
        q[0].push_back(9'h054);
        q[0].push_back(9'h03D);
        q[0].push_back(9'h132);
        model_run();
        rst = 1'b0;
        wait_done(1000, "single");
        vectors++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d tx_en pulses want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d: got id/data %h want %h", i, got_q[i], exp_q[i]); end
            vectors++;
            if (got_gv[i] !== 1'b1) begin errors++; $display("FAIL single_gv%0d: grant_valid %b at tx_en want 1", i, got_gv[i]); end
        end
        vectors++;
        if (bytes_sent !== CNT_W'(3)) begin errors++; $display("FAIL single_bytes_sent: got %0d want 3", bytes_sent); end
        // Busy falls at a negedge; grant drops at the next posedge.
        vectors++;
        if (busy_fall_q.size() == 0 || gv_fall_cyc != busy_fall_q[$] + 1) begin
            errors++; $display("FAIL single_release: grant fell at cyc %0d, last busy fall count %0d", gv_fall_cyc, busy_fall_q.size());
        end
    endtask

    task automatic test_contention();
        apply_reset();
        busy_len = 8;
        q[0].push_back(9'h0A1);
        q[0].push_back(9'h1A2);
        q[1].push_back(9'h1B1);
        model_run();
        rst = 1'b0;
        wait_done(1000, "contention");
        vectors++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL contention_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL contention_byte%0d: got id/data %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        busy_len = 5;
        for (int p = 0; p < 3; p++) begin
            q[0].push_back(9'h111);
            q[1].push_back(9'h122);
        end
        model_run();
        rst = 1'b0;
        wait_done(1000, "rr");
        vectors++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_byte%0d: got id/data %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int npkt;
        int nbyte;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            busy_len = $urandom_range(2, 12);
            for (int r = 0; r < NUM_REQ; r++) begin
                npkt = $urandom_range(1, 3);
                for (int p = 0; p < npkt; p++) begin
                    nbyte = $urandom_range(1, 3);
                    for (int b = 0; b < nbyte; b++)
                        q[r].push_back({(b == nbyte - 1), 8'($urandom)});
                end
            end
            model_run();
            rst = 1'b0;
            wait_done(3000, "random");
            vectors++;
            if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random%0d_count: got %0d want %0d", it, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random%0d_byte%0d: got id/data %h want %h", it, i, got_q[i], exp_q[i]); end
            end
            vectors++;
            if (bytes_sent !== CNT_W'(exp_q.size())) begin errors++; $display("FAIL random%0d_bytes_sent: got %0d want %0d", it, bytes_sent, exp_q.size()); end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        busy_len = 10;
        q[0].push_back(9'h0AA);
        q[1].push_back(9'h15C);
        model_run();
        rst = 1'b0;
        wait_done(1000, "stall");
        vectors++;
        if (stall_seen != exp_stalls) begin errors++; $display("FAIL stall_pulses: got %0d cycles of stall_err want %0d", stall_seen, exp_stalls); end
        // Window opens at the posedge after busy falls (cyc+1); pulse shows STALL_MAX cycles later.
        vectors++;
        if (busy_fall_q.size() == 0 || stall_seen_cyc - busy_fall_q[0] != STALL_MAX + 1) begin
            errors++; $display("FAIL stall_timing: stall_err at cyc %0d, busy fell at %0d, want gap %0d", stall_seen_cyc, (busy_fall_q.size() > 0) ? busy_fall_q[0] : -1, STALL_MAX + 1);
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte%0d: got id/data %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_lost_busy();
        apply_reset();
        busy_lost = 1'b1;
        q[0].push_back(9'h001);
        q[0].push_back(9'h102);
        model_run();
        rst = 1'b0;
        wait_done(500, "lost_busy");
        busy_lost = 1'b0;
        vectors++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL lost_busy_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL lost_busy_byte%0d: got id/data %h want %h", i, got_q[i], exp_q[i]); end
        end
        // BUSY_WAIT_MAX guard cycles, one WAIT_DONE cycle, one SEND handshake cycle.
        vectors++;
        if (tx_en_cyc.size() < 2 || tx_en_cyc[1] - tx_en_cyc[0] != BUSY_WAIT_MAX + 2) begin
            errors++; $display("FAIL lost_busy_spacing: got %0d tx_en pulses, gap %0d want %0d", tx_en_cyc.size(), (tx_en_cyc.size() >= 2) ? tx_en_cyc[1] - tx_en_cyc[0] : -1, BUSY_WAIT_MAX + 2);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        apply_reset();
        busy_len = 20;
        q[0].push_back(9'h077);
        q[0].push_back(9'h178);
        rst = 1'b0;
        while (n < 200 && !(got_q.size() == 1 && tx_busy === 1'b1)) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 200) begin errors++; $display("FAIL reset_mid_first: got %0d bytes after %0d cycles, want 1 in flight", got_q.size(), n); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q[1].push_back(9'h199);
        @(negedge clk);
        vectors++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_gv: got %b want 0", grant_valid); end
        vectors++; if (tx_en !== 1'b0)       begin errors++; $display("FAIL reset_mid_tx_en: got %b want 0", tx_en); end
        vectors++; if (bytes_sent !== '0)    begin errors++; $display("FAIL reset_mid_bytes: got %0d want 0", bytes_sent); end
        vectors++; if (req_ready !== '0)     begin errors++; $display("FAIL reset_mid_ready: got %b want 0", req_ready); end
        model_run();
        got_q.delete();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (n < 50 && grant_valid !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL reset_mid_first_grant: valid %b id %0d want 1/0", grant_valid, grant_id); end
        wait_done(1000, "reset_mid");
        vectors++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL reset_mid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_mid_byte%0d: got id/data %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_random();
        test_stall();
        test_lost_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
